clk_div_cfg_ctrl: RTL and testbench
===================================

Name: clk_div_cfg_ctrl

Overview:
- Sequencer that owns the configuration inputs of the Rx clock divider: DIV_RATIO, CLK_EN and a dedicated divider reset.
- Accepts ratio-change requests over a req/ack handshake, validates them, then applies them glitch-safely: drain, gate, reset divider, load, settle, acknowledge.
- Sits between the Rx config register block and the divider; also performs the post-reset boot configuration.

Parameters:
- INIT_RATIO, 8'd2, ratio applied by the boot sequence after reset.
- MAX_RATIO, 8'd128, largest accepted ratio; larger values are rejected.
- RST_CYCLES, 2, number of I_REF_CLK cycles DIV_RST_N is held low (must be 1..15).
- SETTLE_CYCLES, 4, cycles waited after re-enable before ack (must be 1..15).

Ports:
- I_REF_CLK  in  1  reference clock; also clocks the divider.
- RST_EN  in  1  asynchronous active-low reset.
- CFG_REQ  in  1  level request; held by the requester until CFG_ACK.
- CFG_RATIO  in  8  requested ratio; sampled only on acceptance.
- CFG_ACK  out  1  one-cycle completion pulse.
- CFG_ERR  out  1  valid with CFG_ACK; 1 = rejected, no change made.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- DIV_RATIO  out  8  ratio driven to the divider.
- DIV_CLK_EN  out  1  divider enable.
- DIV_RST_N  out  1  registered active-low divider reset, glitch-free.

Behaviour:
- All outputs are registered.
- Reset values: CFG_ACK=0, CFG_ERR=0, BUSY=1, DIV_RATIO=INIT_RATIO, DIV_CLK_EN=0, DIV_RST_N=0, state=BOOT_RST.
- FSM states: BOOT_RST, IDLE, CHECK, DRAIN, GATE, DRST, LOAD, SETTLE, DONE.
- Boot sequence, no ack:
  - BOOT_RST holds DIV_RST_N=0 for RST_CYCLES.
  - LOAD: DIV_RST_N=1, DIV_CLK_EN=1.
  - SETTLE for SETTLE_CYCLES, then IDLE.
  - BUSY is high 1+RST_CYCLES+SETTLE_CYCLES cycles after reset release; 7 with defaults.
- IDLE: when CFG_REQ=1, capture CFG_RATIO into new_ratio and go to CHECK. CFG_RATIO changes after capture are ignored.
- CHECK (1 cycle):
  - If new_ratio > MAX_RATIO: go to DONE with err=1; divider outputs untouched.
  - Ratios 0 and 1 are legal and mean bypass (the divider passes the reference clock).
- DRAIN: DIV_CLK_EN stays 1. Wait D = max(DIV_RATIO,1) cycles so the current divided period completes.
- GATE (1 cycle): DIV_CLK_EN<=0.
- DRST: DIV_RST_N<=0 for RST_CYCLES, which clears the divider counter/flag so no stale count exceeds the new toggle point.
- LOAD (1 cycle): DIV_RATIO<=new_ratio, DIV_RST_N<=1, DIV_CLK_EN<=1.
- SETTLE: wait SETTLE_CYCLES.
- DONE (1 cycle): CFG_ACK=1, CFG_ERR=err, then IDLE.
- Success latency: CFG_ACK goes high 1+D+1+RST_CYCLES+1+SETTLE_CYCLES+1 cycles after the capture edge.
- Reject latency: 2 cycles after the capture edge.
- If CFG_REQ is still high in the cycle after ACK, a new transaction starts. Requesters must drop REQ on ACK.
- DIV_CLK_EN and DIV_RST_N are never both active-changing in the same cycle.
- DIV_RATIO changes only while DIV_CLK_EN=0 or in LOAD.
- A single down-counter serves all waits: 4-bit for RST/SETTLE, 8-bit for DRAIN.
- Reset asserted mid-transaction: immediate return to reset values, the pending request is dropped with no ack, and the boot sequence reruns with INIT_RATIO.

Optional Feature:
- Macro: CLK_DIV_SAME_SKIP_EN.
- Defined: in CHECK, a valid new_ratio equal to the current DIV_RATIO goes straight to DONE (ack 2 cycles after capture, err=0). The divider is not disturbed.
- Undefined: equal ratios run the full sequence.

Decomposition:
- Shared package/include clk_div_ctrl_pkg holds:
  - state encodings (4-bit localparams);
  - RATIO_W=8 and CNT_W=8;
  - the BYPASS_MAX=1 constant.
- One natural sub-module: clk_div_ctrl_timer, a loadable down-counter.
  - Inputs: load, load value.
  - Output: zero flag.
  - Reused by BOOT_RST, DRAIN, DRST and SETTLE.

Test Plan:
- Reset release, defaults:
  - BUSY high 7 cycles.
  - DIV_RST_N low 2 cycles.
  - Then DIV_RATIO=2, DIV_CLK_EN=1, BUSY=0, no CFG_ACK.
- REQ with ratio 4 from ratio 2:
  - ACK/ERR=1/0 exactly 12 cycles after the capture edge.
  - DIV_CLK_EN low 4 cycles, DIV_RST_N low 2.
  - DIV_RATIO=4 from LOAD.
  - Divider output period 4.
- REQ with ratio 200:
  - ACK with ERR=1, 2 cycles after capture.
  - DIV_RATIO stays 2, DIV_CLK_EN never drops.
- REQ with ratio 1 then ratio 5:
  - First: bypass applied, DRAIN=2 cycles.
  - Second: DRAIN=1 cycle, ACK 11 cycles after capture.
  - Odd divide by 5 observed.
- Assert RST_EN low during DRST of a ratio-6 request:
  - Outputs go to reset values immediately.
  - No ACK.
  - Boot reapplies ratio 2.
- With CLK_DIV_SAME_SKIP_EN, request ratio 2 while at 2:
  - ACK 2 cycles after capture.
  - DIV_CLK_EN and DIV_RST_N constant.
- Without the macro: full 12-cycle sequence.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the Rx clock-divider configuration sequencer.
package clk_div_ctrl_pkg;

    localparam int unsigned RATIO_W = 8;
    localparam int unsigned CNT_W   = 8;

    // Ratios at or below this value put the divider in reference-clock bypass.
    localparam logic [RATIO_W-1:0] BYPASS_MAX = 8'd1;

    typedef enum logic [3:0] {
        ST_BOOT_RST = 4'd0,
        ST_IDLE     = 4'd1,
        ST_CHECK    = 4'd2,
        ST_DRAIN    = 4'd3,
        ST_GATE     = 4'd4,
        ST_DRST     = 4'd5,
        ST_LOAD     = 4'd6,
        ST_SETTLE   = 4'd7,
        ST_DONE     = 4'd8
    } state_e;

    // Cycles needed for the running divided period to complete; bypass counts as one.
    function automatic logic [CNT_W-1:0] drain_len(input logic [RATIO_W-1:0] ratio);
        return (ratio <= BYPASS_MAX) ? CNT_W'(1) : CNT_W'(ratio);
    endfunction

endpackage

// File: rtl/clk_div_ctrl_timer.sv
// Loadable down-counter shared by every timed wait of the sequencer; zero flags expiry.
module clk_div_ctrl_timer
    import clk_div_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             I_REF_CLK,
    input  logic             RST_EN,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
        if (!RST_EN) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Rx clock-divider configuration sequencer: boot config, then validated glitch-safe ratio changes.
// Define CLK_DIV_SAME_SKIP_EN to acknowledge a request for the current ratio without disturbing it.
module clk_div_cfg_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter logic [RATIO_W-1:0] INIT_RATIO    = 8'd2,
    parameter logic [RATIO_W-1:0] MAX_RATIO     = 8'd128,
    parameter int unsigned        RST_CYCLES    = 2,
    parameter int unsigned        SETTLE_CYCLES = 4
) (
    input  logic               I_REF_CLK,
    input  logic               RST_EN,
    input  logic               CFG_REQ,
    input  logic [RATIO_W-1:0] CFG_RATIO,
    output logic               CFG_ACK,
    output logic               CFG_ERR,
    output logic               BUSY,
    output logic [RATIO_W-1:0] DIV_RATIO,
    output logic               DIV_CLK_EN,
    output logic               DIV_RST_N
);

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [RATIO_W-1:0] new_ratio_q, new_ratio_d;
    logic               err_q, err_d;
    logic               boot_q, boot_d;

    logic               ack_q, ack_d;
    logic               err_out_q, err_out_d;
    logic               busy_q, busy_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic               en_q, en_d;
    logic               rstn_q, rstn_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_zero;

    clk_div_ctrl_timer #(
        .RESET_VAL (RST_LOAD)
    ) u_timer (
        .I_REF_CLK (I_REF_CLK),
        .RST_EN    (RST_EN),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .zero      (tmr_zero)
    );

    always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
        if (!RST_EN) begin
            state_q     <= ST_BOOT_RST;
            new_ratio_q <= INIT_RATIO;
            err_q       <= 1'b0;
            boot_q      <= 1'b1;
            ack_q       <= 1'b0;
            err_out_q   <= 1'b0;
            busy_q      <= 1'b1;
            ratio_q     <= INIT_RATIO;
            en_q        <= 1'b0;
            rstn_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            new_ratio_q <= new_ratio_d;
            err_q       <= err_d;
            boot_q      <= boot_d;
            ack_q       <= ack_d;
            err_out_q   <= err_out_d;
            busy_q      <= busy_d;
            ratio_q     <= ratio_d;
            en_q        <= en_d;
            rstn_q      <= rstn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        new_ratio_d = new_ratio_q;
        err_d       = err_q;
        boot_d      = boot_q;
        unique case (state_q)
            ST_BOOT_RST: if (tmr_zero) state_d = ST_LOAD;
            // Ignore REQ during the ack cycle so a new transaction starts only in the cycle after.
            ST_IDLE: begin
                if (CFG_REQ && !ack_q) begin
                    new_ratio_d = CFG_RATIO;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                err_d = 1'b0;
                if (new_ratio_q > MAX_RATIO) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
`ifdef CLK_DIV_SAME_SKIP_EN
                else if (new_ratio_q == ratio_q) begin
                    state_d = ST_DONE;
                end
`endif
                else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN:  if (tmr_zero) state_d = ST_GATE;
            ST_GATE:   state_d = ST_DRST;
            ST_DRST:   if (tmr_zero) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = boot_q ? ST_IDLE : ST_DONE;
                    boot_d  = 1'b0;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_BOOT_RST;
        endcase
    end

    // Enable drops one cycle before the divider reset and returns one cycle after its release.
    always_comb begin
        ack_d     = (state_q == ST_DONE);
        err_out_d = (state_q == ST_DONE) && err_q;
        busy_d    = (state_d != ST_IDLE);
        en_d      = !(state_d inside {ST_BOOT_RST, ST_GATE, ST_DRST, ST_LOAD});
        rstn_d    = !(state_d inside {ST_BOOT_RST, ST_DRST});
        ratio_d   = (state_d == ST_LOAD) ? new_ratio_q : ratio_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (state_d != state_q) begin
            case (state_d)
                ST_DRAIN: begin
                    tmr_load = 1'b1;
                    tmr_val  = drain_len(ratio_q) - CNT_W'(1);
                end
                ST_DRST: begin
                    tmr_load = 1'b1;
                    tmr_val  = RST_LOAD;
                end
                ST_SETTLE: begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end
                default: begin
                    tmr_load = 1'b0;
                    tmr_val  = '0;
                end
            endcase
        end
    end

    assign CFG_ACK    = ack_q;
    assign CFG_ERR    = err_out_q;
    assign BUSY       = busy_q;
    assign DIV_RATIO  = ratio_q;
    assign DIV_CLK_EN = en_q;
    assign DIV_RST_N  = rstn_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: directed scenarios plus randomized ratio requests.
module tb_clk_div_cfg_ctrl;

    localparam int R    = 2;
    localparam int S    = 4;
    localparam int INIT = 2;
    localparam int MAXR = 128;
`ifdef CLK_DIV_SAME_SKIP_EN
    localparam bit SKIP_SAME = 1'b1;
`else
    localparam bit SKIP_SAME = 1'b0;
`endif

    logic       I_REF_CLK = 1'b0;
    logic       RST_EN    = 1'b0;
    logic       CFG_REQ   = 1'b0;
    logic [7:0] CFG_RATIO = 8'd0;
    logic       CFG_ACK, CFG_ERR, BUSY, DIV_CLK_EN, DIV_RST_N;
    logic [7:0] DIV_RATIO;

    int         checks    = 0;
    int         failures  = 0;
    logic [7:0] cur_ratio = 8'(INIT);

    always #5 I_REF_CLK = ~I_REF_CLK;

    clk_div_cfg_ctrl dut (
        .I_REF_CLK  (I_REF_CLK),
        .RST_EN     (RST_EN),
        .CFG_REQ    (CFG_REQ),
        .CFG_RATIO  (CFG_RATIO),
        .CFG_ACK    (CFG_ACK),
        .CFG_ERR    (CFG_ERR),
        .BUSY       (BUSY),
        .DIV_RATIO  (DIV_RATIO),
        .DIV_CLK_EN (DIV_CLK_EN),
        .DIV_RST_N  (DIV_RST_N)
    );

    // Releases reset and checks the boot sequence cycle by cycle.
    task automatic test_boot(input string name);
        logic e_busy, e_en, e_rstn;
        @(negedge I_REF_CLK);
        RST_EN = 1'b1;
        #1;
        for (int j = 0; j <= 9; j++) begin
            if (j > 0) begin
                @(posedge I_REF_CLK);
                #1;
            end
            e_busy = (j < 1 + R + S);
            e_rstn = (j >= R);
            e_en   = (j >= R + 1);
            checks++;
            if ({CFG_ACK, CFG_ERR, BUSY, DIV_CLK_EN, DIV_RST_N, DIV_RATIO} !==
                {1'b0, 1'b0, e_busy, e_en, e_rstn, 8'(INIT)}) begin
                failures++;
                $display("FAIL %s j=%0d got ack=%b err=%b busy=%b en=%b rstn=%b ratio=%0d exp ack=0 err=0 busy=%b en=%b rstn=%b ratio=%0d",
                         name, j, CFG_ACK, CFG_ERR, BUSY, DIV_CLK_EN, DIV_RST_N, DIV_RATIO,
                         e_busy, e_en, e_rstn, INIT);
            end
        end
        cur_ratio = 8'(INIT);
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if ({CFG_ACK, CFG_ERR, BUSY, DIV_CLK_EN, DIV_RST_N, DIV_RATIO} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(INIT)}) begin
            failures++;
            $display("FAIL %s got ack=%b err=%b busy=%b en=%b rstn=%b ratio=%0d exp ack=0 err=0 busy=1 en=0 rstn=0 ratio=%0d",
                     name, CFG_ACK, CFG_ERR, BUSY, DIV_CLK_EN, DIV_RST_N, DIV_RATIO, INIT);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge I_REF_CLK);
        #1;
        check_reset_vals("reset_hold");
        test_boot("boot");
    endtask

    // One request; expected waveform built from the drain/gate/reset/load/settle timing rules.
    task automatic do_txn(input logic [7:0] r, input bit keep, input string name);
        logic [7:0] old, e_ratio;
        logic       e_ack, e_err, e_busy, e_en, e_rstn, g_err;
        int         d, ackk;
        bit         full;
        old  = cur_ratio;
        d    = (old <= 8'd1) ? 1 : int'(old);
        full = (int'(r) <= MAXR) && !(SKIP_SAME && (r == old));
        ackk = full ? (4 + d + R + S) : 2;
        CFG_REQ   = 1'b1;
        CFG_RATIO = r;
        @(posedge I_REF_CLK);
        #1;
        CFG_RATIO = 8'($urandom);
        for (int k = 0; k <= ackk; k++) begin
            if (k > 0) begin
                @(posedge I_REF_CLK);
                #1;
            end
            e_ack  = (k == ackk);
            e_busy = (k < ackk);
            e_err  = e_ack && (int'(r) > MAXR);
            if (full) begin
                e_en    = !((k >= 1 + d) && (k < 3 + d + R));
                e_rstn  = !((k >= 2 + d) && (k < 2 + d + R));
                e_ratio = (k >= 2 + d + R) ? r : old;
            end else begin
                e_en    = 1'b1;
                e_rstn  = 1'b1;
                e_ratio = old;
            end
            g_err = e_ack ? CFG_ERR : 1'b0;
            checks++;
            if ({CFG_ACK, g_err, BUSY, DIV_CLK_EN, DIV_RST_N, DIV_RATIO} !==
                {e_ack, e_err, e_busy, e_en, e_rstn, e_ratio}) begin
                failures++;
                $display("FAIL %s r=%0d k=%0d got ack=%b err=%b busy=%b en=%b rstn=%b ratio=%0d exp ack=%b err=%b busy=%b en=%b rstn=%b ratio=%0d",
                         name, r, k, CFG_ACK, CFG_ERR, BUSY, DIV_CLK_EN, DIV_RST_N, DIV_RATIO,
                         e_ack, e_err, e_busy, e_en, e_rstn, e_ratio);
            end
        end
        if (!keep) CFG_REQ = 1'b0;
        if (full) cur_ratio = r;
        @(posedge I_REF_CLK);
        #1;
        checks++;
        if ({CFG_ACK, BUSY, DIV_CLK_EN, DIV_RST_N, DIV_RATIO} !== {1'b0, 1'b0, 1'b1, 1'b1, cur_ratio}) begin
            failures++;
            $display("FAIL %s_post got ack=%b busy=%b en=%b rstn=%b ratio=%0d exp ack=0 busy=0 en=1 rstn=1 ratio=%0d",
                     name, CFG_ACK, BUSY, DIV_CLK_EN, DIV_RST_N, DIV_RATIO, cur_ratio);
        end
    endtask

    task automatic test_same_ratio;
        do_txn(cur_ratio, 1'b0, "same_ratio");
    endtask

    task automatic test_reject;
        do_txn(8'd200, 1'b0, "reject_200");
    endtask

    task automatic test_ratio_change;
        do_txn(8'd4, 1'b0, "ratio_4");
    endtask

    task automatic test_bypass_then_odd;
        do_txn(8'd1, 1'b0, "bypass_1");
        do_txn(8'd5, 1'b0, "odd_5");
    endtask

    task automatic test_max_boundary;
        do_txn(8'd128, 1'b0, "max_128");
        do_txn(8'd129, 1'b0, "over_129");
        do_txn(8'd0, 1'b0, "bypass_0");
    endtask

    task automatic test_back_to_back;
        do_txn(8'd3, 1'b1, "b2b_first");
        do_txn(8'd7, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid;
        int d;
        d = (cur_ratio <= 8'd1) ? 1 : int'(cur_ratio);
        CFG_REQ   = 1'b1;
        CFG_RATIO = 8'd6;
        @(posedge I_REF_CLK);
        #1;
        repeat (2 + d) @(posedge I_REF_CLK);
        #1;
        checks++;
        if ({DIV_CLK_EN, DIV_RST_N, BUSY} !== 3'b001) begin
            failures++;
            $display("FAIL mid_in_drst got en=%b rstn=%b busy=%b exp en=0 rstn=0 busy=1",
                     DIV_CLK_EN, DIV_RST_N, BUSY);
        end
        #2;
        RST_EN = 1'b0;
        #1;
        check_reset_vals("mid_reset_immediate");
        CFG_REQ = 1'b0;
        repeat (2) @(posedge I_REF_CLK);
        #1;
        check_reset_vals("mid_reset_hold");
        test_boot("reboot");
    endtask

    task automatic test_random;
        logic [7:0] r;
        int         cat;
        for (int i = 0; i < 25; i++) begin
            cat = int'($urandom_range(0, 9));
            case (cat)
                0, 1:    r = 8'($urandom_range(0, 1));
                2:       r = 8'($urandom_range(129, 255));
                3:       r = cur_ratio;
                4:       r = 8'd128;
                default: r = 8'($urandom_range(2, 20));
            endcase
            do_txn(r, 1'($urandom_range(0, 1)), "random");
            if (CFG_REQ == 1'b0) begin
                repeat ($urandom_range(0, 3)) @(posedge I_REF_CLK);
                #1;
            end
        end
        CFG_REQ = 1'b0;
        @(posedge I_REF_CLK);
        #1;
    endtask

    initial begin
        test_reset;
        test_same_ratio;
        test_reject;
        test_ratio_change;
        test_reset_mid;
        test_bypass_then_odd;
        test_max_boundary;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
